// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive FIFO behind a UART receiver. It pushes one byte on each
//               rising edge of byte_ready_i and provides a first-word-fall-through
//               read port with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               byte_i,
    input  logic                     byte_ready_i,
    input  logic                     rd_en_i,
    input  logic                     clr_ovf_i,
    output logic [7:0]               data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ready_q;
    logic              r_ovf;

    logic w_push_evt;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == C_DEPTH);
    assign w_push_evt = byte_ready_i & ~r_ready_q;
    assign w_pop      = rd_en_i & ~w_empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_push     = w_push_evt & (~w_full | w_pop);
    assign w_drop     = w_push_evt & w_full & ~w_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ready_q <= 1'b1;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_ready_q <= byte_ready_i;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            // Setting the flag takes priority over a simultaneous clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= byte_i;
        end
    end

    assign data_o     = r_mem[r_rd_ptr];
    assign empty_o    = w_empty;
    assign full_o     = w_full;
    assign count_o    = r_count;
    assign overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo (DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] byte_i;
    logic       byte_ready_i;
    logic       rd_en_i;
    logic       clr_ovf_i;
    logic [7:0] data_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] count_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.DEPTH(16)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .byte_i       (byte_i),
        .byte_ready_i (byte_ready_i),
        .rd_en_i      (rd_en_i),
        .clr_ovf_i    (clr_ovf_i),
        .data_o       (data_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input int hold);
        byte_i       = b;
        byte_ready_i = 1'b1;
        repeat (hold) tick();
        byte_ready_i = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; byte_i = 8'h00; byte_ready_i = 1'b1;
        rd_en_i = 1'b0; clr_ovf_i = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({empty_o, full_o, count_o, overflow_o} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got e=%b f=%b c=%0d o=%b, want e=1 f=0 c=0 o=0",
                     empty_o, full_o, count_o, overflow_o);
        end
        rst_ni = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_high_ready: got count=%0d empty=%b, want 0/1", count_o, empty_o);
        end
        byte_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp [4];
        exp[0] = 8'hAB; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'h12;
        for (int i = 0; i < 4; i++) push(exp[i], 3);
        n_checks++;
        if (count_o !== 5'd4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d, want 4", count_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (data_o !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %h, want %h", i, data_o, exp[i]);
            end
            pop();
        end
        n_checks++;
        if (empty_o !== 1'b1 || count_o !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_empty: got empty=%b count=%0d, want 1/0", empty_o, count_o);
        end
    endtask

    task automatic test_long_level();
        push(8'h5A, 50);
        n_checks++;
        if (count_o !== 5'd1 || data_o !== 8'h5A) begin
            n_fail++;
            $display("FAIL long_level: got count=%0d data=%h, want 1/5a", count_o, data_o);
        end
        pop();
    endtask

    task automatic test_empty_push_pop();
        byte_i = 8'hC3; byte_ready_i = 1'b1; rd_en_i = 1'b1;
        tick();
        byte_ready_i = 1'b0; rd_en_i = 1'b0;
        tick();
        n_checks++;
        if (count_o !== 5'd1 || data_o !== 8'hC3) begin
            n_fail++;
            $display("FAIL empty_push_pop: got count=%0d data=%h, want 1/c3", count_o, data_o);
        end
        pop();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push(8'(i), 2);
        n_checks++;
        if (full_o !== 1'b1 || overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_at_16: got full=%b ovf=%b, want 1/0", full_o, overflow_o);
        end
        push(8'h10, 2);
        n_checks++;
        if (full_o !== 1'b1 || overflow_o !== 1'b1 || count_o !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_at_17: got full=%b ovf=%b count=%0d, want 1/1/16", full_o, overflow_o, count_o);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (data_o !== 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_data[%0d]: got %h, want %h", i, data_o, 8'(i));
            end
            pop();
        end
        n_checks++;
        if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drained: got empty=%b ovf=%b, want 1/1", empty_o, overflow_o);
        end
        clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
        n_checks++;
        if (overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b, want 0", overflow_o);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1);
        byte_i = 8'h99; byte_ready_i = 1'b1; rd_en_i = 1'b1;
        tick();
        byte_ready_i = 1'b0; rd_en_i = 1'b0;
        tick();
        n_checks++;
        if (count_o !== 5'd16 || overflow_o !== 1'b0 || data_o !== 8'h21) begin
            n_fail++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b data=%h, want 16/0/21", count_o, overflow_o, data_o);
        end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = (i < 15) ? 8'h21 + 8'(i) : 8'h99;
            n_checks++;
            if (data_o !== e) begin
                n_fail++;
                $display("FAIL full_pp_data[%0d]: got %h, want %h", i, data_o, e);
            end
            pop();
        end
    endtask

    task automatic test_set_wins();
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 1);
        byte_i = 8'hEE; byte_ready_i = 1'b1; clr_ovf_i = 1'b1;
        tick();
        byte_ready_i = 1'b0; clr_ovf_i = 1'b0;
        tick();
        n_checks++;
        if (overflow_o !== 1'b1 || count_o !== 5'd16) begin
            n_fail++;
            $display("FAIL set_wins: got ovf=%b count=%0d, want 1/16", overflow_o, count_o);
        end
        repeat (16) pop();
        clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            push(8'h40 + 8'(i), 1);
            n_checks++;
            if (data_o !== 8'h40 + 8'(i) || count_o !== 5'd1) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got data=%h count=%0d, want %h/1", i, data_o, count_o, 8'h40 + 8'(i));
            end
            pop();
        end
        rd_en_i = 1'b1; repeat (3) tick(); rd_en_i = 1'b0;
        n_checks++;
        if (empty_o !== 1'b1 || count_o !== 5'd0 || overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_when_empty: got e=%b c=%0d o=%b, want 1/0/0", empty_o, count_o, overflow_o);
        end
        push(8'h77, 1);
        n_checks++;
        if (data_o !== 8'h77 || count_o !== 5'd1) begin
            n_fail++;
            $display("FAIL after_empty_pop: got data=%h count=%0d, want 77/1", data_o, count_o);
        end
        pop();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i), 1);
        n_checks++;
        if (count_o !== 5'd5) begin
            n_fail++;
            $display("FAIL mid_prefill: got %0d, want 5", count_o);
        end
        byte_i = 8'hBB; byte_ready_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got count=%0d empty=%b full=%b, want 0/1/0", count_o, empty_o, full_o);
        end
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (count_o !== 5'd0 || empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_release: got count=%0d empty=%b, want 0/1", count_o, empty_o);
        end
        byte_ready_i = 1'b0;
        tick();
        push(8'h3C, 2);
        n_checks++;
        if (count_o !== 5'd1 || data_o !== 8'h3C) begin
            n_fail++;
            $display("FAIL mid_recover: got count=%0d data=%h, want 1/3c", count_o, data_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_level();
        test_empty_push_pop();
        test_overflow();
        test_full_push_pop();
        test_set_wins();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have port clk_i  input  1  system clock (100 MHz); all state is on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port byte_i  input  8  received byte from uart_rx byte_o.
REQ-005 SHALL have port byte_ready_i  input  1  uart_rx byte_ready_o; a level that stays high for one or more cycles per byte.
REQ-006 SHALL have port rd_en_i  input  1  pop request from consumer (CPU bus side).
REQ-007 SHALL have port data_o  output  8  head-of-FIFO byte (first-word-fall-through).
REQ-008 SHALL have port empty_o  output  1  FIFO holds zero entries.
REQ-009 SHALL have port full_o  output  1  FIFO holds DEPTH entries.
REQ-010 SHALL have port count_o  output  $clog2(DEPTH)+1  current entry count.
REQ-011 SHALL have port overflow_o  output  1  sticky flag: a byte was dropped.
REQ-012 SHALL have port clr_ovf_i  input  1  clears overflow_o.

Function
REQ-013 SHALL register byte_ready_i into ready_q each cycle and detect a push event as byte_ready_i=1 and ready_q=0 (rising edge only).
REQ-014 SHALL generate exactly one push event per high period of byte_ready_i, however many cycles it lasts.
REQ-015 SHALL write byte_i into the entry at the write pointer on the push-event cycle; the entry is visible on data_o/count_o the next cycle.
REQ-016 SHALL pop on any cycle with rd_en_i=1 and empty_o=0: the read pointer advances, and data_o shows the next entry the following cycle.
REQ-017 SHALL ignore rd_en_i when empty_o=1: no pointer change and no flag change.
REQ-018 SHALL drive data_o combinationally from the memory at the read pointer; data_o is don't-care while empty_o=1.
REQ-019 SHALL keep read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-020 SHALL hold count in a dedicated register: +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-021 SHALL derive empty_o = (count==0) and full_o = (count==DEPTH) from the registered count.
REQ-022 SHALL, on a push event with full_o=1 and no pop in the same cycle, drop the byte, leave memory and pointers unchanged, and set overflow_o=1 the next cycle.
REQ-023 SHALL, on a push event with full_o=1 and a pop in the same cycle, accept both; count stays DEPTH and overflow_o is unchanged.
REQ-024 SHALL, on a push event with empty_o=1 and rd_en_i=1 in the same cycle, accept the push only; the pop is ignored and count becomes 1.
REQ-025 SHALL clear overflow_o on clr_ovf_i=1; if clr_ovf_i and a new overflow occur in the same cycle, overflow_o SHALL end up 1 (set wins).
REQ-026 SHALL use a purely synchronous datapath with no combinational path from byte_i or byte_ready_i to any output.

Reset
REQ-027 SHALL, on rst_ni=0, immediately force read pointer=0, write pointer=0, count=0, overflow_o=0 and ready_q=1.
REQ-028 SHALL, as a consequence, drive empty_o=1, full_o=0, count_o=0 and overflow_o=0 during reset.
REQ-029 SHALL use ready_q=1 at reset so that a byte_ready_i already high at reset release produces no push.
REQ-030 SHALL discard all buffered bytes on reset asserted mid-operation; memory contents need no reset.

Verification
REQ-031 SHALL pass this scenario: push 0xAB, 0xFF, 0x00, 0x12 via uart_rx-style pulses, each held high 3 cycles -> count_o=4; four pops return AB, FF, 00, 12; empty_o=1 afterwards.
REQ-032 SHALL pass this scenario: byte_ready_i held high 50 cycles with byte_i=0x5A -> exactly one entry and count_o=1.
REQ-033 SHALL pass this scenario: DEPTH=16, push 17 bytes 0x00..0x10 with no pops -> full_o=1, overflow_o=1, 16 pops return 0x00..0x0F, and 0x10 is lost; clr_ovf_i -> overflow_o=0.
REQ-034 SHALL pass this scenario: with FIFO full, push edge and rd_en_i in the same cycle -> count_o stays 16, overflow_o stays 0, and the new byte is returned last.
REQ-035 SHALL pass this scenario: push 20, pop 20 interleaved across the pointer wrap -> order preserved; rd_en_i while empty -> no change.
REQ-036 SHALL pass this scenario: assert rst_ni=0 mid-stream with 5 entries while byte_ready_i=1, then release with byte_ready_i still high -> count_o=0 and empty_o=1 during reset, and no push after release.
